// File: rtl/parity_sched.sv
`default_nettype none
// ============================================================================
// Module   : parity_sched
// Purpose  : Round-robin scheduler feeding NREQ words, LSB first, through one
//            shared serial parity unit. Optional shadow check under the macro
//            PARITY_SCHED_CHECK_EN drives a sticky err flag.
// Revision : 1.0  initial release
// ============================================================================
module parity_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    pu_reset,
    output logic                    pu_in,
    input  logic                    pu_out,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic                    result,
    output logic                    err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SHIFT  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             result_q, result_d;

    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   rr_cand;
    logic             found;
    logic [WIDTH-1:0] sel_word;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin : arb
        winner  = last_q;
        found   = 1'b0;
        rr_cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_cand = IDW'((int'(last_q) + k) % NREQ);
            if (!found && req[rr_cand]) begin
                found  = 1'b1;
                winner = rr_cand;
            end
        end
    end

    always_comb begin : word_mux
        sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_word = data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= IDW'(NREQ - 1);
            id_q      <= '0;
            done_id_q <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            result_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            done_id_q <= done_id_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    always_comb begin : fsm
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        done_id_d = done_id_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        grant     = '0;
        busy      = (state_q != IDLE);
        pu_reset  = reset;
        pu_in     = 1'b0;
        done      = 1'b0;
        done_id   = done_id_q;
        result    = result_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    shreg_d = sel_word;
                    id_d    = winner;
                    last_d  = winner;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                grant    = NREQ'(1) << id_q;
                pu_reset = 1'b1;
                cnt_d    = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                pu_in   = shreg_q[0];
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                done      = 1'b1;
                result    = pu_out;
                done_id   = id_q;
                result_d  = pu_out;
                done_id_d = id_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PARITY_SCHED_CHECK_EN
    logic shadow_q;
    logic err_q;

    // Shadow tracks what the parity unit should hold; a disagreement in REPORT latches err.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                CLEAR:   shadow_q <= 1'b1;
                SHIFT:   if (shreg_q[0]) shadow_q <= ~shadow_q;
                REPORT:  if (shadow_q != pu_out) err_q <= 1'b1;
                default: shadow_q <= shadow_q;
            endcase
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_sched
// Purpose  : Bench for parity_sched with a serial parity unit and a
//            transaction-timeline reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_parity_sched;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;
`ifdef PARITY_SCHED_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  data = '0;
    logic [N-1:0]    grant;
    logic            busy, pu_reset, pu_in, pu_out, done, result, err;
    logic [IW-1:0]   done_id;
    logic            pu_q;
    logic            inv_en = 1'b0;

    int checks = 0;
    int failures = 0;

    parity_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data),
        .grant(grant), .busy(busy), .pu_reset(pu_reset), .pu_in(pu_in),
        .pu_out(pu_out), .done(done), .done_id(done_id), .result(result),
        .err(err)
    );

    always #5 clk = ~clk;

    // Serial even-parity unit: 1 after clear, toggles on every 1 shifted in.
    always @(posedge clk) begin
        if (pu_reset) pu_q <= 1'b1;
        else if (pu_in) pu_q <= ~pu_q;
    end
    assign pu_out = pu_q ^ (inv_en & done);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (((r >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    // Reference model: m_ph counts cycles since acceptance (0 = idle).
    int             m_ph = 0;
    int             m_id = 0;
    int             m_last = N - 1;
    int             m_done_id = 0;
    int             m_result = 0;
    int             m_err = 0;
    bit             m_valid = 0;
    logic [W-1:0]   m_word = '0;

    initial forever begin
        int exp_done;
        int exp_res;
        int w;
        logic [W-1:0] t;
        @(negedge clk);
        chk("pu_reset", int'(pu_reset), (reset || (m_valid && m_ph == 1)) ? 1 : 0);
        exp_res = ((^m_word) ? 0 : 1) ^ int'(inv_en);
        if (m_valid) begin
            exp_done = (m_ph == W + 2) ? 1 : 0;
            t = m_word >> (m_ph >= 2 ? m_ph - 2 : 0);
            chk("busy", int'(busy), (m_ph != 0) ? 1 : 0);
            chk("grant", int'(grant), (m_ph == 1) ? (1 << m_id) : 0);
            chk("pu_in", int'(pu_in), (m_ph >= 2 && m_ph <= W + 1) ? int'(t[0]) : 0);
            chk("done", int'(done), exp_done);
            chk("done_id", int'(done_id), exp_done != 0 ? m_id : m_done_id);
            chk("result", int'(result), exp_done != 0 ? exp_res : m_result);
            chk("err", int'(err), m_err);
        end
        if (reset) begin
            m_valid   = 1;
            m_ph      = 0;
            m_last    = N - 1;
            m_done_id = 0;
            m_result  = 0;
            m_err     = 0;
        end else if (m_valid) begin
            if (m_ph == 0) begin
                w = rr_pick(m_last, req);
                if (w >= 0) begin
                    m_id   = w;
                    m_last = w;
                    m_word = W'(data >> (w * W));
                    m_ph   = 1;
                end
            end else if (m_ph == W + 2) begin
                m_done_id = m_id;
                m_result  = exp_res;
                if (CHK != 0 && inv_en) m_err = 1;
                m_ph = 0;
            end else begin
                m_ph++;
            end
        end
    end

    task automatic set_word(input int id, input logic [W-1:0] word);
        logic [N*W-1:0] mask;
        mask = (N*W)'({W{1'b1}}) << (id * W);
        data = (data & ~mask) | ((N*W)'(word) << (id * W));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Drives one request from cycle 0 and checks grant/done timing and result literals.
    task automatic run_txn(input logic [N-1:0] r, input int id, input logic [W-1:0] word,
                           input int exp_res, input bit scramble);
        bit seen;
        wait_idle();
        set_word(id, word);
        req  = r;
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            tick();
            if (c == 1) begin
                chk("t_grant", int'(grant), 1 << id);
                req = '0;
                if (scramble) set_word(id, ~word);
            end
            if (done) begin
                seen = 1;
                chk("t_done_cycle", c, W + 2);
                chk("t_result", int'(result), exp_res);
                chk("t_done_id", int'(done_id), id);
            end
        end
        if (!seen) chk("t_done_timeout", 0, 1);
    endtask

    initial begin
        int ids[5];
        int tms[5];
        int ng;
        bit saw_done;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pu_in", int'(pu_in), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_pu_reset", int'(pu_reset), 1);
        reset = 1'b0;

        run_txn(4'b0001, 0, 8'hA5, 1, 0);
        run_txn(4'b0100, 2, 8'h07, 0, 0);
        run_txn(4'b0100, 2, 8'h00, 1, 0);
        run_txn(4'b0100, 2, 8'hFF, 1, 0);
        run_txn(4'b1000, 3, 8'h13, 0, 1);

        // All requesters held: fair rotation from requester 0.
        wait_idle();
        pulse_reset();
        set_word(0, 8'h11); set_word(1, 8'h3F); set_word(2, 8'h80); set_word(3, 8'hC3);
        req = 4'b1111;
        ng = 0;
        for (int c = 0; c < 80 && ng < 5; c++) begin
            tick();
            if (grant != 0) begin
                for (int i = 0; i < N; i++) if (grant[i]) ids[ng] = i;
                tms[ng] = c;
                ng++;
            end
        end
        req = '0;
        chk("rr_grants", ng, 5);
        if (ng == 5) begin
            chk("rr_id0", ids[0], 0);
            chk("rr_id1", ids[1], 1);
            chk("rr_id2", ids[2], 2);
            chk("rr_id3", ids[3], 3);
            chk("rr_id4", ids[4], 0);
            for (int i = 1; i < 5; i++) chk("rr_spacing", tms[i] - tms[i-1], W + 3);
        end

        // Reset in the 4th SHIFT cycle aborts the transaction.
        wait_idle();
        set_word(0, 8'h3C);
        req = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) req = '0;
        end
        chk("abort_busy_before", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("abort_pu_reset", int'(pu_reset), 1);
        tick();
        chk("abort_busy_after", int'(busy), 0);
        reset = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) saw_done = 1;
            tick();
        end
        chk("abort_no_done", int'(saw_done), 0);
        run_txn(4'b0010, 1, 8'h01, 0, 0);

        // Corrupted parity readback.
        inv_en = 1'b1;
        run_txn(4'b0001, 0, 8'hA5, 0, 0);
        tick();
        inv_en = 1'b0;
        chk("inj_err", int'(err), CHK);
        run_txn(4'b0010, 1, 8'h0F, 1, 0);
        tick();
        chk("inj_err_sticky", int'(err), CHK);
        pulse_reset();
        chk("inj_err_cleared", int'(err), 0);

        // Random traffic, including req/data churn while busy and rare resets.
        for (int c = 0; c < 500; c++) begin
            tick();
            req = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 3) == 0) data = (N*W)'($urandom);
            reset = ($urandom_range(0, 99) == 0);
        end
        reset = 1'b0;
        req = '0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/parity_sched.md
# parity_sched

Round-robin scheduler that shares one serial parity unit among `NREQ` requesters. Each requester presents a `WIDTH`-bit word. The block grants one requester, clears the parity unit, and shifts the word in serially, LSB first. It then samples the unit's even-parity output and returns it tagged with the requester index. It sits between word-level clients and the 1-bit serial parity FSM.

## Interface
- `WIDTH`, 8, bits per word (≥1)
- `NREQ`, 4, number of requesters (≥2)
- `IDW`, `$clog2(NREQ)`, width of requester index

Reset: synchronous, active-high, on `reset`; clock is `clk`.

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous active-high reset
- `req`  in  NREQ  per-requester request, level
- `data`  in  NREQ*WIDTH  word i at `[i*WIDTH +: WIDTH]`
- `grant`  out  NREQ  one-hot, one-cycle pulse: word accepted
- `busy`  out  1  transaction in progress
- `pu_reset`  out  1  reset to parity unit
- `pu_in`  out  1  serial bit to parity unit
- `pu_out`  in  1  parity unit output (1 = even count of ones)
- `done`  out  1  one-cycle result strobe
- `done_id`  out  IDW  index of the served requester
- `result`  out  1  sampled `pu_out`, valid with `done`
- `err`  out  1  sticky shadow-check mismatch (see Configuration)

## Operation
- States: IDLE, CLEAR, SHIFT, REPORT.
- **IDLE**
  - If `req` ≠ 0, pick a winner by round robin: search starts at `last+1` mod NREQ.
  - Latch `data[winner]` into the shift register, latch the winner index, set `last` to the winner, go to CLEAR.
  - With no request, stay in IDLE.
- **CLEAR**
  - `grant[winner]` = 1 and `pu_reset` = 1 for exactly this cycle.
  - Bit counter cleared; go to SHIFT.
- **SHIFT**
  - `pu_in` = shift register bit 0; shift right each cycle.
  - After WIDTH cycles, go to REPORT.
- **REPORT**
  - `done` = 1, `result` = `pu_out`, `done_id` = latched index; go to IDLE.
- `busy` = (state ≠ IDLE). `pu_in` = 0 outside SHIFT.
- `pu_reset` = `reset` OR (state == CLEAR). This guarantees the unit is cleared on any block reset.
- Requester rules:
  - Hold `req` and `data` stable until `grant`; deassert `req` in the grant cycle if no further word is pending.
  - `data` is sampled only at the IDLE→CLEAR edge; later changes do not affect the transaction.
- `req` changes during CLEAR/SHIFT/REPORT are ignored until the next IDLE.
- `done_id` and `result` hold their last values between strobes.

## Timing
- Request sampled in IDLE cycle 0. `grant` appears in cycle 1, SHIFT runs in cycles 2..WIDTH+1, `done` appears in cycle WIDTH+2.
- Minimum spacing between grants is WIDTH+3 cycles. One IDLE cycle always separates transactions.
- `pu_out` read in REPORT reflects the clear edge plus exactly WIDTH shift edges.
- Reset state: IDLE, `last` = NREQ-1 (requester 0 has first priority). Output reset values:
  - `grant` = 0, `busy` = 0, `pu_in` = 0, `done` = 0, `done_id` = 0, `result` = 0, `err` = 0
  - `pu_reset` = 1 while `reset` is high
- Reset mid-transaction: next cycle is IDLE and no `done` is produced. The aborted requester must re-request. `last` returns to NREQ-1.
- All requesters asserted: service order is 0,1,2,…,NREQ-1,0, with no starvation.

## Configuration
- `PARITY_SCHED_CHECK_EN` defined:
  - A shadow parity flop runs alongside the unit: set to 1 in CLEAR, toggled on each `pu_in` = 1 in SHIFT.
  - In REPORT, if shadow ≠ `pu_out`, `err` is set. It stays set until `reset`.
- Undefined: no shadow logic is built and `err` is tied to 0.

## Test plan
The bench instantiates the real parity unit and uses WIDTH=8, NREQ=4.
- `req`=0001, word0=8'hA5 → `grant`=0001 in cycle 1; `done`=1 in cycle 10 with `result`=1, `done_id`=0.
- `req`=0100, word2=8'h07 → `done` in cycle 10 with `result`=0, `done_id`=2. Repeat with 8'h00 → 1 and 8'hFF → 1.
- `req`=1111 held continuously → grants to 0,1,2,3,0 spaced 11 cycles apart; each `done_id` matches its grant.
- `reset` pulsed in the 4th SHIFT cycle → IDLE next cycle, `busy`=0, no `done`, `pu_reset`=1 during reset. A following `req`=0010 (word=8'h01) completes with `result`=0, `done_id`=1.
- Change `data` after `grant` → `result` still reflects the sampled word.
- With `PARITY_SCHED_CHECK_EN`, invert `pu_out` in REPORT → `err`=1 from the next cycle, held through later transactions until `reset`. Without the macro, `err`=0 throughout.
